sync_reset_reg: RTL and testbench
=================================

Name: sync_reset_reg

Overview:
- Registered data path with a synchronous reset: a parameterized shift pipeline that captures `din` on rising `clk` and presents it on `dout` after STAGES cycles.
- Used as the reference synchronous-reset flop primitive and as a short delay/retiming stage in control paths.
- Reset is sampled only on clock edges; there is no asynchronous clear path.

Parameters:
- WIDTH, 1: bit width of `din`/`dout`; legal range 1..64.
- STAGES, 1: number of register stages between `din` and `dout`; legal range 1..8. Values below 1 are an elaboration error.
- RST_VAL, {WIDTH{1'b0}}: value loaded into every stage while reset is asserted.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rstn, input, 1: synchronous reset, active-high (1 = reset asserted, sampled at the rising `clk` edge). The port name is retained as-is; polarity is high.
- din, input, WIDTH: data input, sampled at the rising `clk` edge.
- dout, output, WIDTH: data output, driven directly from the last register stage (no combinational path from any input).

Behaviour:
- Storage: `stage[0..STAGES-1]`, each WIDTH bits; `dout = stage[STAGES-1]`.
- Rising `clk` with `rstn`=1: every stage <= RST_VAL.
  - Reset has priority over `din`.
  - `dout` equals RST_VAL from this edge onward.
- Rising `clk` with `rstn`=0: `stage[0] <= din`; `stage[i] <= stage[i-1]` for i = 1..STAGES-1.
- Latency: a `din` value sampled at edge k appears on `dout` after edge k+STAGES-1 (STAGES=1 gives one-cycle latency). Throughput is one value per cycle.
- Reset is not in the sensitivity list:
  - Assertion or deassertion between edges has no effect until the next rising edge.
  - A reset pulse that does not span a rising edge is ignored entirely.
- Reset deassertion: the first edge with `rstn`=0 loads `din` into `stage[0]`. The remaining stages hold RST_VAL until the new data shifts through. There is no additional recovery delay.
- Reset mid-operation: any in-flight data in all stages is discarded at the reset edge. No partial flush.
- Before the first rising edge, stage contents are unknown (X in simulation). No initial-value dependency is allowed in RTL.
- `din` glitches between edges do not affect `dout`. Only the value present at the rising edge is captured.
- Setup/hold relative to `clk` is the user's responsibility; the block is not a metastability synchronizer.
- `dout` changes only on rising `clk` edges.

Test Plan:
- Reset capture (clk period 10 ns, rising edges at 5, 15, 25 ns, ...; WIDTH=1, STAGES=1): `rstn`=1, `din`=0 for 0..13 ns, then `rstn`=0, `din`=1 → `dout`=0 after 5 ns; `dout`=1 after the 15 ns edge.
- Data follow: `din`=1 at 13 ns, 0 at 30 ns, 1 at 53 ns → `dout`=1 at 15 ns, 0 at 35 ns, 1 at 55 ns; no change between edges.
- Reset priority: `rstn`=1 and `din`=1 across edge 45 ns → `dout`=0 (RST_VAL) after 45 ns; resumes following `din` at the first edge with `rstn`=0.
- Short reset pulse: `rstn`=1 from 46 ns to 52 ns (no rising edge inside the pulse) → `dout` unaffected.
- Pipeline depth (WIDTH=8, STAGES=3, RST_VAL=8'hA5): reset, then `din`=8'h01, 8'h02, 8'h03 on consecutive edges → `dout` reads A5, A5, 01, 02, 03; asserting reset mid-stream → `dout`=A5 on the next edge.
- Long run: toggle random `din` for 1000 ns with `rstn`=0 → `dout` matches `din` delayed STAGES edges at every edge.

Source files
------------

// File: rtl/sync_reset_reg.sv
// sync_reset_reg: register pipeline with a synchronous, active-high reset.
// The block captures din on the rising clk edge and presents it on dout
// STAGES edges later. Throughput is one value per cycle.
//
// Parameters:
//   WIDTH   - data width, 1..64
//   STAGES  - number of register stages between din and dout, 1..8
//   RST_VAL - value loaded into every stage while reset is asserted
//
// Ports:
//   clk  - clock; every stage updates on the rising edge
//   rstn - synchronous reset, active HIGH despite the name, sampled at rising clk
//   din  - data input, sampled at rising clk
//   dout - last register stage; there is no combinational path from any input
module sync_reset_reg #(
  parameter int unsigned      WIDTH   = 1,
  parameter int               STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Reject out-of-range configurations at elaboration time.
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("sync_reset_reg: STAGES must be in 1..8");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sync_reset_reg: WIDTH must be in 1..64");
  end

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift pipeline. Reset wins over din and clears all in-flight data at once.
  // rstn is not in the sensitivity list, so a pulse that misses an edge is ignored.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign dout = r_stage[STAGES-1];

endmodule

// File: tb/tb_sync_reset_reg.sv
// Testbench for sync_reset_reg. It drives two instances: a 1-bit, 1-stage
// instance and an 8-bit, 3-stage instance with RST_VAL = 8'hA5. A queue
// scoreboard per instance holds the expected dout value for each coming edge.
module tb_sync_reset_reg;

  localparam logic [7:0] RV2 = 8'hA5;

  logic       clk;
  logic       rstn1, rstn2;
  logic       din1,  dout1;
  logic [7:0] din2,  dout2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic       q1[$];
  logic [7:0] q2[$];
  logic       prev1;
  logic [7:0] prev2;
  bit         have_prev = 1'b0;

  sync_reset_reg #(.WIDTH(1), .STAGES(1), .RST_VAL(1'b0)) u_dut1 (
    .clk  (clk),
    .rstn (rstn1),
    .din  (din1),
    .dout (dout1)
  );

  sync_reset_reg #(.WIDTH(8), .STAGES(3), .RST_VAL(RV2)) u_dut2 (
    .clk  (clk),
    .rstn (rstn2),
    .din  (din2),
    .dout (dout2)
  );

  // 10 ns period, rising edges at 5, 15, 25 ns, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Update both scoreboards for the coming edge from the current inputs,
  // then compare both outputs 1 ns after that edge.
  task automatic finish_edge();
    logic       e1;
    logic [7:0] e2;
    if (rstn1) begin
      q1.delete();
      q1.push_back(1'b0);
    end else begin
      q1.push_back(din1);
    end
    if (rstn2) begin
      q2.delete();
      repeat (3) q2.push_back(RV2);
    end else begin
      q2.push_back(din2);
    end
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    @(posedge clk);
    #1;
    check_eq("dout1", 64'(dout1), 64'(e1));
    check_eq("dout2", 64'(dout2), 64'(e2));
    prev1     = e1;
    prev2     = e2;
    have_prev = 1'b1;
  endtask

  // Drive at the falling edge. The optional glitch inverts every input
  // (including a short reset pulse) between edges; the DUT must ignore it.
  task automatic step(input logic r1, input logic d1, input logic r2,
                      input logic [7:0] d2, input bit glitch);
    @(negedge clk);
    rstn1 = r1; din1 = d1; rstn2 = r2; din2 = d2;
    if (glitch) begin
      #1;
      rstn1 = ~r1; din1 = ~d1; rstn2 = ~r2; din2 = ~d2;
      #2;
      rstn1 = r1; din1 = d1; rstn2 = r2; din2 = d2;
    end
    #1;
    if (have_prev) begin
      check_eq("hold1", 64'(dout1), 64'(prev1));
      check_eq("hold2", 64'(dout2), 64'(prev2));
    end
    finish_edge();
  endtask

  initial begin
    // Reset is asserted across the first edge at 5 ns.
    rstn1 = 1'b1; din1 = 1'b0; rstn2 = 1'b1; din2 = 8'h00;
    finish_edge();

    // dut1 leaves reset and follows din. dut2 holds reset for one more edge.
    step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
    // dut2 shifts in 01, 02, 03. Glitches between edges must not show up.
    step(1'b0, 1'b1, 1'b0, 8'h01, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h02, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h03, 1'b1);
    // Reset priority on dut1: reset and din=1 across the same edge.
    step(1'b1, 1'b1, 1'b0, 8'h04, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h05, 1'b0);
    // Mid-stream reset on dut2 discards the data in flight.
    step(1'b0, 1'b0, 1'b1, 8'h06, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h07, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h08, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h09, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h0A, 1'b0);

    // Long run with reset held low: random data and random glitches.
    for (int i = 0; i < 120; i++) begin
      step(1'b0, 1'($urandom), 1'b0, 8'($urandom), 1'($urandom));
    end

    // Mixed run with occasional resets.
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 9) == 0), 1'($urandom),
           1'($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net: the bench above is cycle-bounded, so this only fires if it stalls.
  initial begin
    #100000;
    $display("FAIL timeout: stalled at %0t, expected finish before 100000", $time);
    $fatal(1, "timeout");
  end

endmodule
